ahbl_axi_rdch_fifo: RTL and testbench
=====================================

AHBL_AXI_RDCH_FIFO -- requirements
Module: ahbl_axi_rdch_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 64-bit entries; power of two, 2..16.
REQ-002 SHALL have parameter AWIDTH, default 3, log2(DEPTH) pointer width.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 RVALID  input  1  AXI read-data beat valid.
REQ-006 RREADY  output  1  beat accepted when RVALID&RREADY; equals !full.
REQ-007 RDATA  input  64  AXI read data beat.
REQ-008 RRESP  input  2  AXI read response for the beat.
REQ-009 RLAST  input  1  last beat of burst.
REQ-010 LANE_SEL  input  2  lanes to forward for this beat: 2'b01 lower, 2'b10 upper, 2'b11 both; sampled with beat; 2'b00 is illegal.
REQ-011 HVALID  output  1  32-bit word available on HDATA.
REQ-012 HREADY_IN  input  1  AHB side consumes word when HVALID&HREADY_IN.
REQ-013 HDATA  output  32  current word.
REQ-014 HERR  output  1  word carries SLVERR/DECERR.
REQ-015 HLAST  output  1  final word of the final beat of a burst.
REQ-016 LEVEL  output  AWIDTH+1  entry occupancy 0..DEPTH.

Function
REQ-017 Push: on RVALID&RREADY, store {RDATA,RRESP,RLAST,LANE_SEL} at write pointer; pointer wraps DEPTH-1 -> 0.
REQ-018 Full when LEVEL==DEPTH; RREADY low while full; empty when LEVEL==0.
REQ-019 Output is fall-through from head entry; HVALID rises the cycle after the push into an empty FIFO (1-cycle latency).
REQ-020 Half-sequencer states: IDLE (empty), LO (presenting RDATA[31:0]), HI (presenting RDATA[63:32]).
REQ-021 Entry becomes head: LANE_SEL 2'b11 or 2'b01 -> LO; 2'b10 -> HI.
REQ-022 In LO with consume: LANE_SEL 2'b11 -> HI, same entry; 2'b01 -> pop entry.
REQ-023 In HI with consume: pop entry; next state LO/HI per next head, or IDLE if FIFO becomes empty.
REQ-024 HLAST = head RLAST AND the word is the last lane of that entry.
REQ-025 Pop and push in the same cycle: LEVEL unchanged; new beat behind head, no word lost or duplicated.
REQ-026 Push into empty in same cycle as nothing pending: no bypass; HVALID only next cycle.
REQ-027 HDATA/HERR/HLAST stable while HVALID & !HREADY_IN.
REQ-028 LEVEL arithmetic is AWIDTH+1 bits; never exceeds DEPTH or goes below 0.

Reset
REQ-029 On ARESETN low, immediately: pointers 0, LEVEL 0, state IDLE, HVALID 0, HERR 0, HLAST 0, RREADY 0.
REQ-030 RREADY goes 1 the first ACLK edge after ARESETN deasserts; storage contents not reset.
REQ-031 Reset mid-burst discards all entries and any partly consumed entry.

Configuration
REQ-032 Macro AHBL_AXI_RDCH_RESP_CHK_EN defined: HERR = head RRESP[1] (SLVERR or DECERR) for every word of that entry.
REQ-033 Macro undefined: RRESP not stored, HERR tied 0, storage width 67 bits instead of 69.

Structure
REQ-034 Shared package holds lane-select encodings, half-state encoding, RRESP codes (OKAY, EXOKAY, SLVERR, DECERR).
REQ-035 One sub-module ahbl_axi_rdch_mem: synchronous-write, asynchronous-read DEPTH x entry-width storage array.

Verification
REQ-036 Four beats 0x11112222_33334444.. LANE_SEL 2'b11, RLAST on 4th, HREADY_IN=1 -> 8 words lower-first 0x33334444, 0x11112222..., HLAST only on 8th word.
REQ-037 Nine beats with HREADY_IN=0, DEPTH=8 -> RREADY low after 8th push, LEVEL=8, 9th beat held until one entry fully popped.
REQ-038 Beats with LANE_SEL 2'b01 then 2'b10 -> exactly one word each, lower then upper half, LEVEL decrements per word.
REQ-039 Continuous push and consume at full rate -> LEVEL constant, no gaps in HDATA order across pointer wrap at entry 7 -> 0.
REQ-040 Macro defined, beat RRESP=2'b10 -> HERR=1 on both words; macro undefined -> HERR=0.
REQ-041 ARESETN pulsed low with LEVEL=5 mid-consume -> HVALID 0 and LEVEL 0 immediately, RREADY 1 one cycle after release.

Source files
------------

// File: rtl/ahbl_axi_rdch_fifo_pkg.sv
// Shared encodings for the AXI read-data to AHB-Lite word FIFO.
// Optional macro AHBL_AXI_RDCH_RESP_CHK_EN stores RRESP per entry and drives HERR.
package ahbl_axi_rdch_fifo_pkg;

  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } half_state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } rresp_t;

`ifdef AHBL_AXI_RDCH_RESP_CHK_EN
  localparam int RESP_W = 2;
`else
  localparam int RESP_W = 0;
`endif

  // Entry layout, MSB first: RDATA, [RRESP], RLAST, LANE_SEL
  localparam int ENTRY_W = 64 + RESP_W + 1 + 2;

  // Half presented first when an entry reaches the head
  function automatic half_state_t first_half(input logic [1:0] lane);
    return (lane == LANE_HI) ? ST_HI : ST_LO;
  endfunction

endpackage

// File: rtl/ahbl_axi_rdch_fifo_if.sv
// AXI read-data channel (in) and AHB-side word stream (out) of the read FIFO.
interface ahbl_axi_rdch_fifo_if #(
  parameter int AWIDTH = 3
);
  logic              RVALID;
  logic              RREADY;
  logic [63:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic [1:0]        LANE_SEL;
  logic              HVALID;
  logic              HREADY_IN;
  logic [31:0]       HDATA;
  logic              HERR;
  logic              HLAST;
  logic [AWIDTH:0]   LEVEL;

  modport slave (
    input  RVALID, RDATA, RRESP, RLAST, LANE_SEL, HREADY_IN,
    output RREADY, HVALID, HDATA, HERR, HLAST, LEVEL
  );

  modport master (
    output RVALID, RDATA, RRESP, RLAST, LANE_SEL, HREADY_IN,
    input  RREADY, HVALID, HDATA, HERR, HLAST, LEVEL
  );
endinterface

// File: rtl/ahbl_axi_rdch_mem.sv
// Entry storage: synchronous write, two asynchronous read ports (head and head+1).
module ahbl_axi_rdch_mem #(
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 3,
  parameter int WIDTH  = 67
) (
  input  logic              ACLK,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [AWIDTH-1:0] raddr0,
  input  logic [AWIDTH-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge ACLK) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_reg[raddr0];
  assign rdata1 = mem_reg[raddr1];

endmodule

// File: rtl/ahbl_axi_rdch_fifo.sv
// AXI 64-bit read beats in, 32-bit AHB words out via a LO/HI half sequencer.
// Define AHBL_AXI_RDCH_RESP_CHK_EN to carry RRESP and flag error words on HERR.
module ahbl_axi_rdch_fifo
  import ahbl_axi_rdch_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AWIDTH = 3
) (
  input logic                  ACLK,
  input logic                  ARESETN,
  ahbl_axi_rdch_fifo_if.slave  bus
);

  logic [AWIDTH-1:0]  wr_ptr_reg;
  logic [AWIDTH-1:0]  rd_ptr_reg;
  logic [AWIDTH-1:0]  rd_ptr_inc;
  logic [AWIDTH:0]    level_reg;
  logic [AWIDTH:0]    level_next;
  half_state_t        state_reg;
  half_state_t        state_next;
  logic               rready_reg;

  logic               push;
  logic               pop;
  logic               consume;
  logic               hvalid;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ENTRY_W-1:0] nxt_entry;
  logic [63:0]        head_data;
  logic               head_last;
  logic [1:0]         head_lane;
  logic               head_err;
  logic               unused_bits;

  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  ahbl_axi_rdch_mem #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH),
    .WIDTH  (ENTRY_W)
  ) u_mem (
    .ACLK   (ACLK),
    .we     (push),
    .waddr  (wr_ptr_reg),
    .wdata  (wr_entry),
    .raddr0 (rd_ptr_reg),
    .raddr1 (rd_ptr_inc),
    .rdata0 (head_entry),
    .rdata1 (nxt_entry)
  );

`ifdef AHBL_AXI_RDCH_RESP_CHK_EN
  assign wr_entry    = {bus.RDATA, bus.RRESP, bus.RLAST, bus.LANE_SEL};
  // RRESP[1] set means SLVERR or DECERR
  assign head_err    = head_entry[4];
  assign unused_bits = ^{nxt_entry[ENTRY_W-1:2], head_entry[3]};
`else
  assign wr_entry    = {bus.RDATA, bus.RLAST, bus.LANE_SEL};
  assign head_err    = 1'b0;
  assign unused_bits = ^{nxt_entry[ENTRY_W-1:2], bus.RRESP};
`endif

  assign head_data = head_entry[ENTRY_W-1 -: 64];
  assign head_last = head_entry[2];
  assign head_lane = head_entry[1:0];

  assign hvalid  = (state_reg != ST_IDLE);
  assign push    = bus.RVALID & rready_reg;
  assign consume = hvalid & bus.HREADY_IN;
  assign pop     = consume & ((state_reg == ST_HI) || (head_lane != LANE_BOTH));

  assign level_next = level_reg + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);

  // After a pop the new head is either the stored entry behind it or,
  // when the FIFO held only one entry, the beat being written this cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (push) begin
          state_next = first_half(bus.LANE_SEL);
        end
      end
      ST_LO, ST_HI: begin
        if (consume && (state_reg == ST_LO) && (head_lane == LANE_BOTH)) begin
          state_next = ST_HI;
        end else if (pop) begin
          if (level_reg == (AWIDTH+1)'(1)) begin
            state_next = push ? first_half(bus.LANE_SEL) : ST_IDLE;
          end else begin
            state_next = first_half(nxt_entry[1:0]);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      state_reg  <= ST_IDLE;
      rready_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      level_reg  <= level_next;
      state_reg  <= state_next;
      rready_reg <= (level_next != (AWIDTH+1)'(DEPTH));
    end
  end

  assign bus.RREADY = rready_reg;
  assign bus.HVALID = hvalid;
  assign bus.HDATA  = (state_reg == ST_HI) ? head_data[63:32] : head_data[31:0];
  assign bus.HERR   = hvalid & head_err;
  assign bus.HLAST  = hvalid & head_last & ((state_reg == ST_HI) || (head_lane != LANE_BOTH));
  assign bus.LEVEL  = level_reg;

endmodule

// File: tb/tb_ahbl_axi_rdch_fifo.sv
// Scoreboard bench: expected words queued on beat acceptance, compared on consume.
module tb_ahbl_axi_rdch_fifo;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [1:0]  lane;
  } beat_t;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        l;
  } word_t;

`ifdef AHBL_AXI_RDCH_RESP_CHK_EN
  localparam bit RESP_CHK = 1'b1;
`else
  localparam bit RESP_CHK = 1'b0;
`endif

  logic ACLK;
  logic ARESETN;

  ahbl_axi_rdch_fifo_if #(.AWIDTH(3)) rd_if ();

  ahbl_axi_rdch_fifo #(.DEPTH(8), .AWIDTH(3)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (rd_if)
  );

  int    errors = 0;
  int    checks = 0;
  int    n_words = 0;
  beat_t beat_q[$];
  word_t exp_q[$];
  beat_t drv_beat;
  word_t got_w;
  word_t exp_w;
  word_t held_w;
  bit    held_vld = 1'b0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input logic [63:0] d, input logic [1:0] resp,
                                    input logic last, input logic [1:0] lane);
    beat_t b;
    b.data = d; b.resp = resp; b.last = last; b.lane = lane;
    return b;
  endfunction

  function automatic void push_exp(input beat_t b);
    word_t w;
    w.e = RESP_CHK ? b.resp[1] : 1'b0;
    if (b.lane != 2'b10) begin
      w.d = b.data[31:0];
      w.l = b.last && (b.lane == 2'b01);
      exp_q.push_back(w);
    end
    if (b.lane != 2'b01) begin
      w.d = b.data[63:32];
      w.l = b.last;
      exp_q.push_back(w);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wait_level(input string tag, input logic [3:0] lvl, input int limit);
    int n = 0;
    while (rd_if.LEVEL !== lvl && n < limit) begin
      cycles(1);
      n++;
    end
    check_val(tag, rd_if.LEVEL, lvl);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rd_if.HREADY_IN = 1'b1;
    while ((beat_q.size() != 0 || rd_if.LEVEL != 0) && n < 400) begin
      cycles(1);
      n++;
    end
    check_val({tag, "_level"}, rd_if.LEVEL, 0);
    check_val({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // Beat driver: present head of beat_q, retire it when handshake is seen
  initial begin
    rd_if.RVALID   = 1'b0;
    rd_if.RDATA    = '0;
    rd_if.RRESP    = '0;
    rd_if.RLAST    = 1'b0;
    rd_if.LANE_SEL = 2'b01;
    forever begin
      @(posedge ACLK);
      #2;
      if (ARESETN && beat_q.size() > 0) begin
        drv_beat       = beat_q[0];
        rd_if.RVALID   = 1'b1;
        rd_if.RDATA    = drv_beat.data;
        rd_if.RRESP    = drv_beat.resp;
        rd_if.RLAST    = drv_beat.last;
        rd_if.LANE_SEL = drv_beat.lane;
      end else begin
        rd_if.RVALID = 1'b0;
      end
      @(negedge ACLK);
      if (ARESETN && rd_if.RVALID && rd_if.RREADY) begin
        push_exp(beat_q[0]);
        void'(beat_q.pop_front());
      end
    end
  end

  // Word monitor: compare consumed words and hold-stability while stalled
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      held_vld = 1'b0;
    end else begin
      got_w = {rd_if.HDATA, rd_if.HERR, rd_if.HLAST};
      if (held_vld && rd_if.HVALID) begin
        check_val("stall_hold", got_w, held_w);
      end
      held_vld = 1'b0;
      if (rd_if.HVALID && rd_if.HREADY_IN) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_word", got_w, 0);
        end else begin
          exp_w = exp_q.pop_front();
          n_words++;
          $display("word %0d data=%h err=%b last=%b", n_words, rd_if.HDATA, rd_if.HERR, rd_if.HLAST);
          check_val("word", got_w, exp_w);
        end
      end else if (rd_if.HVALID) begin
        held_vld = 1'b1;
        held_w   = got_w;
      end
    end
  end

  initial begin
    ARESETN         = 1'b0;
    rd_if.HREADY_IN = 1'b0;
    cycles(3);
    check_val("rst_hvalid", rd_if.HVALID, 0);
    check_val("rst_level", rd_if.LEVEL, 0);
    check_val("rst_rready", rd_if.RREADY, 0);
    ARESETN = 1'b1;
    #1;
    check_val("rready_before_edge", rd_if.RREADY, 0);
    cycles(1);
    check_val("rready_after_edge", rd_if.RREADY, 1);

    // Push into empty: HVALID only after the accepting edge
    beat_q.push_back(mk_beat(64'hAAAA_0001_BBBB_0001, 2'b00, 1'b1, 2'b11));
    @(negedge ACLK);
    check_val("lat_pre_hvalid", rd_if.HVALID, 0);
    @(posedge ACLK);
    #1;
    check_val("lat_post_hvalid", rd_if.HVALID, 1);
    check_val("lat_post_level", rd_if.LEVEL, 1);
    drain("lat");

    // Four full beats, HLAST only on the eighth word
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back(mk_beat({32'h1111_2222 + i, 32'h3333_4444 + i}, 2'b00, i == 3, 2'b11));
    end
    drain("burst4");

    // Fill to DEPTH, ninth beat held until an entry is fully popped
    rd_if.HREADY_IN = 1'b0;
    for (int i = 0; i < 9; i++) begin
      beat_q.push_back(mk_beat({32'h5000_0000 + i, 32'h6000_0000 + i}, 2'b00, i == 8, 2'b11));
    end
    wait_level("full_level", 4'd8, 40);
    check_val("full_rready", rd_if.RREADY, 0);
    cycles(2);
    check_val("full_hold_level", rd_if.LEVEL, 8);
    check_val("full_hold_beat", beat_q.size(), 1);
    rd_if.HREADY_IN = 1'b1;
    cycles(1);
    rd_if.HREADY_IN = 1'b0;
    check_val("half_pop_level", rd_if.LEVEL, 8);
    check_val("half_pop_rready", rd_if.RREADY, 0);
    rd_if.HREADY_IN = 1'b1;
    cycles(1);
    rd_if.HREADY_IN = 1'b0;
    check_val("pop_level", rd_if.LEVEL, 7);
    check_val("pop_rready", rd_if.RREADY, 1);
    cycles(1);
    check_val("refill_level", rd_if.LEVEL, 8);
    drain("full");

    // Single-lane beats: one word each, LEVEL drops per word
    rd_if.HREADY_IN = 1'b0;
    beat_q.push_back(mk_beat(64'hDEAD_0010_CAFE_0010, 2'b00, 1'b0, 2'b01));
    beat_q.push_back(mk_beat(64'hDEAD_0020_CAFE_0020, 2'b00, 1'b1, 2'b10));
    wait_level("lane_level", 4'd2, 20);
    rd_if.HREADY_IN = 1'b1;
    cycles(1);
    rd_if.HREADY_IN = 1'b0;
    check_val("lane_lo_level", rd_if.LEVEL, 1);
    rd_if.HREADY_IN = 1'b1;
    cycles(1);
    check_val("lane_hi_level", rd_if.LEVEL, 0);
    drain("lane");

    // Full-rate push and pop across pointer wrap
    rd_if.HREADY_IN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back(mk_beat({32'h0, 32'h7000_0000 + i}, 2'b00, 1'b0, 2'b01));
    end
    wait_level("stream_pre", 4'd4, 20);
    for (int i = 4; i < 24; i++) begin
      beat_q.push_back(mk_beat({32'h0, 32'h7000_0000 + i}, 2'b00, i == 23, 2'b01));
    end
    rd_if.HREADY_IN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      check_val("stream_level", rd_if.LEVEL, 4);
    end
    drain("stream");

    // Response propagation
    beat_q.push_back(mk_beat(64'h0BAD_0001_0BAD_0002, 2'b10, 1'b0, 2'b11));
    beat_q.push_back(mk_beat(64'h0BAD_0003_0BAD_0004, 2'b11, 1'b0, 2'b11));
    beat_q.push_back(mk_beat(64'h0600_0005_0600_0006, 2'b01, 1'b1, 2'b11));
    drain("resp");

    // Random lanes, responses and consumer back-pressure
    for (int i = 0; i < 30; i++) begin
      beat_q.push_back(mk_beat({$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))));
    end
    for (int i = 0; i < 60; i++) begin
      rd_if.HREADY_IN = 1'($urandom_range(0, 1));
      cycles(1);
      check_val("rand_level_bound", rd_if.LEVEL <= 8, 1);
    end
    drain("rand");

    // Reset mid-consume with five entries
    rd_if.HREADY_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat_q.push_back(mk_beat({32'h9000_0000 + i, 32'h8000_0000 + i}, 2'b00, i == 4, 2'b11));
    end
    wait_level("rst_pre_level", 4'd5, 20);
    rd_if.HREADY_IN = 1'b1;
    cycles(1);
    rd_if.HREADY_IN = 1'b0;
    ARESETN = 1'b0;
    #1;
    check_val("mid_rst_hvalid", rd_if.HVALID, 0);
    check_val("mid_rst_level", rd_if.LEVEL, 0);
    check_val("mid_rst_rready", rd_if.RREADY, 0);
    check_val("mid_rst_hlast", rd_if.HLAST, 0);
    beat_q.delete();
    exp_q.delete();
    cycles(2);
    ARESETN = 1'b1;
    #1;
    check_val("rel_rready_pre", rd_if.RREADY, 0);
    cycles(1);
    check_val("rel_rready_post", rd_if.RREADY, 1);
    check_val("rel_hvalid", rd_if.HVALID, 0);
    beat_q.push_back(mk_beat(64'h1234_5678_9ABC_DEF0, 2'b00, 1'b1, 2'b11));
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
